// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one combinational ALU between two requesters.
// It runs one operation at a time and returns the registered result to the requester that issued it.
module alu_arbiter (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid_0,
    input  logic        req_valid_1,
    output logic        req_ready_0,
    output logic        req_ready_1,
    input  logic [15:0] req_ain_0,
    input  logic [15:0] req_ain_1,
    input  logic [15:0] req_bin_0,
    input  logic [15:0] req_bin_1,
    input  logic [1:0]  req_op_0,
    input  logic [1:0]  req_op_1,
    output logic        rsp_valid_0,
    output logic        rsp_valid_1,
    input  logic        rsp_ready_0,
    input  logic        rsp_ready_1,
    output logic [15:0] rsp_out,
    output logic [2:0]  rsp_flags,
    output logic [15:0] alu_ain,
    output logic [15:0] alu_bin,
    output logic [1:0]  alu_op,
    input  logic [15:0] alu_out,
    input  logic        alu_z,
    input  logic        alu_v,
    input  logic        alu_n
);

    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

    state_t      state;
    logic        last;
    logic        owner;
    logic [15:0] a_q;
    logic [15:0] b_q;
    logic [1:0]  op_q;
    logic        gnt_0;
    logic        gnt_1;
    logic        rsp_done;

    // On a tie, the requester that was not served last wins.
    always_comb begin
        gnt_0 = 1'b0;
        gnt_1 = 1'b0;
        if (state == IDLE) begin
            gnt_0 = req_valid_0 && (!req_valid_1 || last);
            gnt_1 = req_valid_1 && (!req_valid_0 || !last);
        end
    end

    assign req_ready_0 = gnt_0;
    assign req_ready_1 = gnt_1;
    assign rsp_done    = (rsp_valid_0 && rsp_ready_0) || (rsp_valid_1 && rsp_ready_1);

    assign alu_ain = a_q;
    assign alu_bin = b_q;
    assign alu_op  = op_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            last        <= 1'b1;
            owner       <= 1'b0;
            a_q         <= 16'h0000;
            b_q         <= 16'h0000;
            op_q        <= 2'b00;
            rsp_out     <= 16'h0000;
            rsp_flags   <= 3'b000;
            rsp_valid_0 <= 1'b0;
            rsp_valid_1 <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_0) begin
                        a_q   <= req_ain_0;
                        b_q   <= req_bin_0;
                        op_q  <= req_op_0;
                        owner <= 1'b0;
                        state <= EXEC;
                    end else if (gnt_1) begin
                        a_q   <= req_ain_1;
                        b_q   <= req_bin_1;
                        op_q  <= req_op_1;
                        owner <= 1'b1;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_out     <= alu_out;
                    rsp_flags   <= {alu_z, alu_v, alu_n};
                    rsp_valid_0 <= !owner;
                    rsp_valid_1 <= owner;
                    state       <= RESP;
                end
                RESP: begin
                    // Result and flags stay frozen until the owner takes them.
                    if (rsp_done) begin
                        rsp_valid_0 <= 1'b0;
                        rsp_valid_1 <= 1'b0;
                        last        <= owner;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
